// File: rtl/instr_fetch_port_pkg.sv
// Shared encodings for the instruction fetch port: IF enable/mask levels,
// the empty instruction word and the fetch FSM state encodings.
package instr_fetch_port_pkg;

  localparam logic INSTR_RD_EN  = 1'b1;
  localparam logic INSTR_RD_DIS = 1'b0;
  localparam logic MASK_EN      = 1'b1;
  localparam logic MASK_DIS     = 1'b0;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_port.sv
// Memory-side responder for the IF stage: one outstanding valid/ready read,
// a one-entry instruction buffer, a hold request and flush discard.
module instr_fetch_port
  import instr_fetch_port_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_rd_en_i,
  input  logic [ADDR_W-1:0]  instr_addr_i,
  input  logic               flush_i,
  output logic [INSTR_W-1:0] instr_rd_o,
  output logic               instr_mask_o,
  output logic               fetch_hold_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [ADDR_W-1:0]  mem_req_addr_o,
  input  logic               mem_rsp_valid_i,
  input  logic [INSTR_W-1:0] mem_rsp_data_i,
  output logic               mem_rsp_ready_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~{{(ADDR_W-2){1'b0}}, 2'b11};

  fetch_state_e       state_r;
  fetch_state_e       state_s;
  logic [INSTR_W-1:0] buf_r;
  logic               buf_vld_r;
  logic [ADDR_W-1:0]  addr_r;
  logic               flush_pend_r;
  logic               req_valid_r;
  logic               rsp_ready_r;
  logic               launch_s;
  logic               rsp_take_s;
  logic               consume_s;

  assign launch_s   = (state_r == FETCH_IDLE) && (instr_rd_en_i == INSTR_RD_EN)
                      && !buf_vld_r && !flush_i;
  assign rsp_take_s = (state_r == FETCH_WAIT) && mem_rsp_valid_i && !flush_i;
  assign consume_s  = buf_vld_r && (instr_rd_en_i == INSTR_RD_EN);

  // Next-state logic for the single-outstanding read FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      FETCH_IDLE: begin
        if (launch_s) state_s = FETCH_REQ;
        else          state_s = FETCH_IDLE;
      end
      FETCH_REQ: begin
        // A flush seen while requesting (now or earlier) turns the handshake into a drop
        if (mem_req_ready_i) begin
          if (flush_i || flush_pend_r) state_s = FETCH_DROP;
          else                         state_s = FETCH_WAIT;
        end else begin
          state_s = FETCH_REQ;
        end
      end
      FETCH_WAIT: begin
        if (mem_rsp_valid_i) state_s = FETCH_IDLE;
        else if (flush_i)    state_s = FETCH_DROP;
        else                 state_s = FETCH_WAIT;
      end
      FETCH_DROP: begin
        if (mem_rsp_valid_i) state_s = FETCH_IDLE;
        else                 state_s = FETCH_DROP;
      end
      default: state_s = FETCH_IDLE;
    endcase
  end

  // State register plus registered bus handshake outputs decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= FETCH_IDLE;
      req_valid_r <= 1'b0;
      rsp_ready_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_valid_r <= (state_s == FETCH_REQ);
      rsp_ready_r <= (state_s == FETCH_WAIT) || (state_s == FETCH_DROP);
    end
  end

  // Request address, captured word-aligned at launch and held until the next launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (launch_s) begin
      addr_r <= instr_addr_i & ALIGN_MASK;
    end else begin
      addr_r <= addr_r;
    end
  end

  // Remembers a flush raised while the request is still waiting for ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pend_r <= 1'b0;
    end else if (state_s == FETCH_DROP) begin
      flush_pend_r <= 1'b0;
    end else if ((state_r == FETCH_REQ) && flush_i) begin
      flush_pend_r <= 1'b1;
    end else begin
      flush_pend_r <= flush_pend_r;
    end
  end

  // One-entry instruction buffer; flush beats fill and consumption
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r     <= INSTR_W'(ZERO_WORD);
      buf_vld_r <= 1'b0;
    end else if (flush_i) begin
      buf_r     <= buf_r;
      buf_vld_r <= 1'b0;
    end else if (rsp_take_s) begin
      buf_r     <= mem_rsp_data_i;
      buf_vld_r <= 1'b1;
    end else if (consume_s) begin
      buf_r     <= buf_r;
      buf_vld_r <= 1'b0;
    end else begin
      buf_r     <= buf_r;
      buf_vld_r <= buf_vld_r;
    end
  end

  // Delivery mux toward IF
  always_comb begin
    instr_rd_o   = INSTR_W'(ZERO_WORD);
    instr_mask_o = MASK_EN;
    if (buf_vld_r) begin
      instr_rd_o   = buf_r;
      instr_mask_o = MASK_DIS;
    end else begin
      instr_rd_o   = INSTR_W'(ZERO_WORD);
      instr_mask_o = MASK_EN;
    end
  end

  assign fetch_hold_o    = (instr_rd_en_i == INSTR_RD_EN) && !buf_vld_r && !flush_i;
  assign mem_req_valid_o = req_valid_r;
  assign mem_req_addr_o  = addr_r;
  assign mem_rsp_ready_o = rsp_ready_r;

endmodule
